// File: rtl/wrr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_burst_arbiter
//   Weighted round-robin arbiter for three burst requesters (A=0, B=1, C=2).
//   A granted requester keeps its tenure until it has moved a number of beats
//   equal to its latched weight (0 counts as 1), or until it drops its request.
//   At release the round-robin pointer moves to owner+1, and the next owner is
//   chosen from that new search order at the same edge, so there is no gap
//   between back-to-back grants.
//
// Ports
//   CLK          : clock, all state on rising edge
//   ASynReset_N  : asynchronous active-low reset
//   i_Req        : per-requester request level
//   i_Weight_A/B/C : beats allowed per tenure (WW bits each)
//   i_Ready      : downstream accepts a beat this cycle
//   o_Grant      : registered one-hot grant (or zero)
//   o_GrantVld   : registered OR of o_Grant
//   o_Owner      : registered index of the granted requester, 0 when idle
//   o_BeatCnt    : registered beats completed in the current tenure
// -----------------------------------------------------------------------------
module wrr_burst_arbiter #(
  parameter int unsigned WW   = 4,
  parameter int unsigned NREQ = 3
) (
  input  logic            CLK,
  input  logic            ASynReset_N,
  input  logic [NREQ-1:0] i_Req,
  input  logic [WW-1:0]   i_Weight_A,
  input  logic [WW-1:0]   i_Weight_B,
  input  logic [WW-1:0]   i_Weight_C,
  input  logic            i_Ready,
  output logic [NREQ-1:0] o_Grant,
  output logic            o_GrantVld,
  output logic [1:0]      o_Owner,
  output logic [WW-1:0]   o_BeatCnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          r_State;
  logic [1:0]      r_Ptr;
  logic [1:0]      r_Owner;
  logic [NREQ-1:0] r_Grant;
  logic            r_GrantVld;
  logic [WW-1:0]   r_BeatCnt;
  logic [WW-1:0]   r_Limit;
  // Cleared by reset and set at the first edge afterwards; holds off the
  // first grant until the second rising edge out of reset.
  logic            r_Armed;

  state_t          w_StateNxt;
  logic [1:0]      w_PtrNxt;
  logic [1:0]      w_OwnerNxt;
  logic [NREQ-1:0] w_GrantNxt;
  logic [WW-1:0]   w_BeatCntNxt;
  logic [WW-1:0]   w_LimitNxt;

  logic            w_InGrant;
  logic            w_Beat;
  logic            w_LastBeat;
  logic            w_OwnerDrop;
  logic            w_Release;
  logic [1:0]      w_SearchPtr;
  logic [2:0]      w_Pick;
  logic            w_PickVld;
  logic [1:0]      w_PickIdx;

  // Index following idx in the modulo-3 search ring.
  function automatic logic [1:0] f_next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // First requesting index starting at ptr; result is {found, index}.
  function automatic logic [2:0] f_pick(input logic [1:0]      ptr,
                                        input logic [NREQ-1:0] req);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    idx   = ptr;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = f_next_idx(idx);
    end
    return {found, sel};
  endfunction

  // Beat limit for a new tenure; a zero weight still allows one beat.
  function automatic logic [WW-1:0] f_limit(input logic [1:0]    idx,
                                            input logic [WW-1:0] wa,
                                            input logic [WW-1:0] wb,
                                            input logic [WW-1:0] wc);
    logic [WW-1:0] w;
    case (idx)
      2'd0:    w = wa;
      2'd1:    w = wb;
      default: w = wc;
    endcase
    return (w == '0) ? WW'(1) : w;
  endfunction

  // ---------------------------------------------------------------------------
  // Release detection and next-owner search
  // ---------------------------------------------------------------------------
  assign w_InGrant   = (r_State == ST_GRANT);
  assign w_Beat      = w_InGrant && i_Req[r_Owner] && i_Ready;
  assign w_LastBeat  = w_Beat && ((r_BeatCnt + WW'(1)) == r_Limit);
  assign w_OwnerDrop = w_InGrant && !i_Req[r_Owner];
  assign w_Release   = w_LastBeat || w_OwnerDrop;

  // On release the search starts after the old owner, so the old owner is
  // considered last; otherwise (idle) it starts at the stored pointer.
  assign w_SearchPtr = w_Release ? f_next_idx(r_Owner) : r_Ptr;
  assign w_Pick      = f_pick(w_SearchPtr, i_Req);
  assign w_PickVld   = w_Pick[2];
  assign w_PickIdx   = w_Pick[1:0];

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_StateNxt   = r_State;
    w_PtrNxt     = r_Ptr;
    w_OwnerNxt   = r_Owner;
    w_GrantNxt   = r_Grant;
    w_BeatCntNxt = r_BeatCnt;
    w_LimitNxt   = r_Limit;

    case (r_State)
      ST_IDLE: begin
        if (r_Armed && w_PickVld) begin
          w_StateNxt   = ST_GRANT;
          w_OwnerNxt   = w_PickIdx;
          w_GrantNxt   = NREQ'(1) << w_PickIdx;
          w_BeatCntNxt = '0;
          w_LimitNxt   = f_limit(w_PickIdx, i_Weight_A, i_Weight_B, i_Weight_C);
        end
      end

      ST_GRANT: begin
        if (w_Release) begin
          w_PtrNxt     = w_SearchPtr;
          w_BeatCntNxt = '0;
          if (w_PickVld) begin
            w_StateNxt = ST_GRANT;
            w_OwnerNxt = w_PickIdx;
            w_GrantNxt = NREQ'(1) << w_PickIdx;
            w_LimitNxt = f_limit(w_PickIdx, i_Weight_A, i_Weight_B, i_Weight_C);
          end else begin
            w_StateNxt = ST_IDLE;
            w_OwnerNxt = '0;
            w_GrantNxt = '0;
          end
        end else if (w_Beat) begin
          w_BeatCntNxt = r_BeatCnt + WW'(1);
        end
      end

      default: begin
        w_StateNxt   = ST_IDLE;
        w_OwnerNxt   = '0;
        w_GrantNxt   = '0;
        w_BeatCntNxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge ASynReset_N) begin
    if (!ASynReset_N) begin
      r_State    <= ST_IDLE;
      r_Ptr      <= '0;
      r_Owner    <= '0;
      r_Grant    <= '0;
      r_GrantVld <= 1'b0;
      r_BeatCnt  <= '0;
      r_Limit    <= '0;
      r_Armed    <= 1'b0;
    end else begin
      r_State    <= w_StateNxt;
      r_Ptr      <= w_PtrNxt;
      r_Owner    <= w_OwnerNxt;
      r_Grant    <= w_GrantNxt;
      r_GrantVld <= |w_GrantNxt;
      r_BeatCnt  <= w_BeatCntNxt;
      r_Limit    <= w_LimitNxt;
      r_Armed    <= 1'b1;
    end
  end

  assign o_Grant    = r_Grant;
  assign o_GrantVld = r_GrantVld;
  assign o_Owner    = r_Owner;
  assign o_BeatCnt  = r_BeatCnt;

endmodule

// File: doc/wrr_burst_arbiter.md
WRR_BURST_ARBITER -- requirements
Module: wrr_burst_arbiter

Interface
REQ-001 Parameter WW, default 4, width of each per-requester weight field.
REQ-002 Parameter NREQ, fixed at 3; requester index 0 = A, 1 = B, 2 = C.
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 ASynReset_N  input  1  reset, asynchronous assert and active-low.
REQ-005 i_Req  input  3  per-requester request level; bit n set = requester n holds data.
REQ-006 i_Weight_A, i_Weight_B, i_Weight_C  input  WW each  beats allowed per grant tenure.
REQ-007 i_Ready  input  1  downstream sink accepts a beat this cycle.
REQ-008 o_Grant  output  3  registered one-hot grant, or all-zero.
REQ-009 o_GrantVld  output  1  registered; equals OR of o_Grant.
REQ-010 o_Owner  output  2  registered index of granted requester; 0 when no grant.
REQ-011 o_BeatCnt  output  WW  registered beats completed in the current tenure.

Function
REQ-012 The block SHALL define a beat as a cycle with o_Grant[n]=1, i_Req[n]=1 and i_Ready=1.
REQ-013 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one owner).
REQ-014 The block SHALL keep a round-robin pointer ptr (0..2); search order is ptr, ptr+1, ptr+2 mod 3.
REQ-015 IDLE: if i_Req nonzero, the first requester in search order SHALL be granted at the next edge (1-cycle request-to-grant latency); else remain IDLE.
REQ-016 On entering GRANT, the owner's weight SHALL be latched into an internal limit; a latched weight of 0 SHALL be treated as 1; later weight changes SHALL not affect the current tenure.
REQ-017 GRANT: o_BeatCnt SHALL increment by 1 per beat and hold otherwise, including while i_Ready=0.
REQ-018 GRANT SHALL release when (a) a beat occurs with o_BeatCnt+1 equal to the limit, or (b) the owner's i_Req is 0 in a cycle.
REQ-019 On release ptr SHALL become owner+1 mod 3, and at the same edge the block SHALL grant the first requesting index in the new search order (the old owner is searched last), with o_BeatCnt cleared to 0; with no requests it SHALL go IDLE.
REQ-020 A back-to-back handover SHALL produce no idle cycle between grants; o_Grant SHALL never have more than one bit set.
REQ-021 Simultaneous release and new requests SHALL be resolved using the updated ptr, not the old one.
REQ-022 Requests from non-owners SHALL never preempt a tenure before REQ-018 release.
REQ-023 o_BeatCnt SHALL not wrap; its maximum value is limit-1 before release.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 While ASynReset_N=0: FSM=IDLE, ptr=0, o_Grant=3'b000, o_GrantVld=0, o_Owner=0, o_BeatCnt=0, immediately and without a clock edge.
REQ-026 Reset asserted mid-tenure SHALL drop the grant at once; after release the first grant SHALL follow REQ-015 with ptr=0.
REQ-027 The first grant after reset deassertion SHALL occur no earlier than the second rising edge with i_Req nonzero.

Verification
REQ-028 Weights A=2,B=3,C=1; i_Req=3'b111 held; i_Ready=1 -> grant sequence A,A,B,B,B,C,A,A,... with no gaps; o_BeatCnt 0,1,0,1,2,0,0,1.
REQ-029 Weights all 4; only B requests; i_Ready toggles 1,0,1,0 -> B holds grant; o_BeatCnt advances only on Ready=1 cycles; B re-granted after its 4th beat (ptr moves to C, then A, then B).
REQ-030 A granted with weight 5; A drops i_Req after 2 beats while C requests -> C granted on the next edge; A's tenure ends with o_BeatCnt=2.
REQ-031 Weight_C=0; only C requests -> C granted for exactly 1 beat per tenure, then re-granted with no idle cycle.
REQ-032 Reset asserted during B tenure with o_BeatCnt=2 -> all outputs zero without a clock edge; after release with i_Req=3'b110, B granted first.
REQ-033 Weight_A changed from 2 to 7 during an A tenure -> tenure ends after 2 beats; the next A tenure uses 7.
